// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-port arbiter: opcode constants,
// FSM state encoding and the registered-operation record.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] OP_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] OP_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] OP_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] OP_SUB = 4'b0110;
    localparam logic [CTRL_W-1:0] OP_SLT = 4'b0111;
    localparam logic [CTRL_W-1:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [CTRL_W-1:0] ctrl;
        logic              owner;
    } op_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; unknown opcodes produce a zero result.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    // NOTE: result gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        result = '0;
        case (ctrl)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_SLT: result = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Shares a single ALU between two requesters with round-robin grant and
// one operation in flight (IDLE -> EXEC -> RESP).
module alu_arbiter
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_ctrl,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_ctrl,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_zero,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_zero,
    output logic        busy
);

    state_t            state_q;
    state_t            state_d;
    op_t               op_q;
    logic              last_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;

    logic              gnt;
    logic              accept;
    logic              rsp_hs;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    // Port 1 wins when it is the only requester or when port 0 was served last.
    assign gnt    = req1_valid & (~req0_valid | ~last_q);
    assign accept = req0_ready | req1_ready;
    assign rsp_hs = (state_q == RESP) & (op_q.owner ? rsp1_ready : rsp0_ready);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are masked during reset so nothing is offered or accepted that cycle.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                req0_ready = ~reset & req0_valid & ~gnt;
                req1_ready = ~reset & req1_valid & gnt;
            end
            RESP: begin
                rsp0_valid = ~reset & ~op_q.owner;
                rsp1_valid = ~reset & op_q.owner;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            last_q   <= 1'b1;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q.a     <= gnt ? req1_a : req0_a;
                op_q.b     <= gnt ? req1_b : req0_b;
                op_q.ctrl  <= gnt ? req1_ctrl : req0_ctrl;
                op_q.owner <= gnt;
                last_q     <= gnt;
            end
            if (state_q == EXEC) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
            end
        end
    end

    alu u_alu (
        .a      (op_q.a),
        .b      (op_q.b),
        .ctrl   (op_q.ctrl),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a predictor queues expected responses on
// each acceptance, an independent monitor checks every presented response.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp1_zero;
    logic        busy;

    alu_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ctrl   (req0_ctrl),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ctrl   (req1_ctrl),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .rsp0_zero   (rsp0_zero),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result),
        .rsp1_zero   (rsp1_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        logic [31:0] result;
        logic        zero;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   vectors = 0;
    int   miscompares = 0;
    int   last_served = 1;
    bit   resp_seen = 0;
    logic exp_r0, exp_r1;
    logic [31:0] model_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return (a < b) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    // Predictor: expected grant from round-robin rules, expected result on acceptance.
    always @(negedge clk) begin
        if (reset) begin
            check("ready_in_reset", {30'd0, req0_ready, req1_ready}, 32'd0);
            sbq.delete();
            last_served = 1;
        end else begin
            if (busy) begin
                exp_r0 = 1'b0;
                exp_r1 = 1'b0;
            end else if (req0_valid && req1_valid) begin
                exp_r0 = (last_served == 1);
                exp_r1 = (last_served == 0);
            end else begin
                exp_r0 = req0_valid;
                exp_r1 = req1_valid;
            end
            check("req_ready", {30'd0, req0_ready, req1_ready}, {30'd0, exp_r0, exp_r1});
            if (req0_valid && req0_ready) begin
                model_res = ref_alu(req0_ctrl, req0_a, req0_b);
                sbq.push_back('{port: 0, result: model_res, zero: (model_res == 0), cyc: cyc});
                last_served = 0;
            end else if (req1_valid && req1_ready) begin
                model_res = ref_alu(req1_ctrl, req1_a, req1_b);
                sbq.push_back('{port: 1, result: model_res, zero: (model_res == 0), cyc: cyc});
                last_served = 1;
            end
        end
    end

    // Monitor: every presented response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            check("rsp_valid_in_reset", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
            resp_seen = 0;
        end else if (rsp0_valid || rsp1_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            end else begin
                cur = sbq[0];
                check("rsp_owner", {30'd0, rsp1_valid, rsp0_valid}, (cur.port == 0) ? 32'd1 : 32'd2);
                if (!resp_seen) check("latency", cyc, cur.cyc + 2);
                resp_seen = 1;
                check("rsp_result", (cur.port == 0) ? rsp0_result : rsp1_result, cur.result);
                check("rsp_zero", {31'd0, (cur.port == 0) ? rsp0_zero : rsp1_zero}, {31'd0, cur.zero});
                check("busy_in_resp", {31'd0, busy}, 32'd1);
                if ((cur.port == 0) ? rsp0_ready : rsp1_ready) begin
                    void'(sbq.pop_front());
                    resp_seen = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int port, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit got = 0;
        if (port == 0) begin
            req0_valid = 1'b1; req0_ctrl = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_ctrl = op; req1_a = a; req1_b = b;
        end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = (port == 0) ? req0_ready : req1_ready;
        end
        step();
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
        if (!got) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (sbq.size() == 0) && !busy;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        step();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [3:0] ops [8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) step();
        @(negedge clk);
        check("reset_rsp0_result", rsp0_result, 32'd0);
        check("reset_rsp1_result", rsp1_result, 32'd0);
        check("reset_zero", {30'd0, rsp0_zero, rsp1_zero}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b0;
        req0_valid = 1'b0;
        step();

        // Single ADD on port 0
        send(0, 4'd2, 32'd5, 32'd7);
        drain();

        // Simultaneous pairs after reset: port 0 first, then the next pair port 1 first
        apply_reset();
        fork
            send(0, 4'd6, 32'd9, 32'd9);
            send(1, 4'd1, 32'hF0, 32'h0F);
        join
        drain();
        fork
            send(0, 4'd0, 32'hFF00FF00, 32'h0FF00FF0);
            send(1, 4'd2, 32'd100, 32'd23);
        join
        drain();

        // Response backpressure while port 1 is waiting
        rsp0_ready = 1'b0;
        fork
            send(0, 4'd2, 32'd3, 32'd4);
            begin step(); send(1, 4'd1, 32'd1, 32'd2); end
            begin repeat (7) step(); rsp0_ready = 1'b1; end
        join
        drain();

        // Unknown opcode and unsigned compare
        send(1, 4'hF, 32'd123, 32'd456);
        send(0, 4'd7, 32'hFFFFFFFF, 32'd1);
        drain();

        // Reset during EXEC aborts the operation; pending request accepted afterwards
        send(0, 4'd2, 32'd1, 32'd1);
        reset = 1'b1;
        req0_valid = 1'b1; req0_ctrl = 4'd1; req0_a = 32'hA5; req0_b = 32'h5A00;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {31'd0, busy}, 32'd0);
        check("pending_accepted", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        drain();

        // Wrap-around boundaries
        send(0, 4'd6, 32'd0, 32'd1);
        send(0, 4'd2, 32'hFFFFFFFF, 32'd1);
        drain();

        // Randomized traffic with backpressure, dropped requests and rare resets
        for (int i = 0; i < 600; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_ctrl  = ops[$urandom_range(0, 7)];
            req1_ctrl  = ops[$urandom_range(0, 7)];
            req0_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            req1_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            req0_b     = ($urandom_range(0, 4) == 0) ? req0_a : $urandom;
            req1_b     = ($urandom_range(0, 4) == 0) ? req1_a : $urandom;
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            reset      = ($urandom_range(0, 149) == 0);
            step();
        end
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drain();
        check("queue_empty", sbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
